bias_ram_ctrl: RTL and testbench

- Controls the bias RAM: a 128-bit write port and a read port that returns the biases for one output-channel group (Channel_Out_Num*32 bits) per address.
- Accepts a bias stream from the AXI input path with a valid/ready handshake and writes it into the RAM.
- Sequences per-group bias reads for the convolution engine and tracks the group index with wrap-around.
- Sits between the DMA input demux and the bias RAM wrapper, and is driven by the layer control FSM.

---
 rtl/bias_ram_ctrl_pkg.sv | 14 +
 rtl/bias_rd_seq.sv | 58 +++++
 rtl/bias_ram_ctrl.sv | 116 +++++++++++
 tb/tb_bias_ram_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_ram_ctrl_pkg.sv
// Shared widths, load FSM encodings and the read-pipeline tag for the bias RAM controller.
package bias_ram_ctrl_pkg;
    localparam int AXI_WIDTH_DATA_IN = 128;
    localparam int CHANNEL_OUT_NUM   = 8;

    localparam logic [1:0] BIAS_IDLE  = 2'd0;
    localparam logic [1:0] BIAS_LOAD  = 2'd1;
    localparam logic [1:0] BIAS_READY = 2'd2;

    typedef struct packed {
        logic vld;
        logic last;
    } rd_tag_t;
endpackage

// File: rtl/bias_rd_seq.sv
// Group index sequencer with wrap/restart and an RD_LAT-deep valid/last pipeline.
module bias_rd_seq
    import bias_ram_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req,
    input  logic                 i_restart,
    input  logic                 i_flush,
    input  logic [ADDR_BITS-2:0] i_groups,
    output logic [ADDR_BITS-1:0] o_rd_addr,
    output logic                 o_valid,
    output logic                 o_last
);
    localparam logic [ADDR_BITS-2:0] G_ONE = 1;

    logic [ADDR_BITS-2:0] r_idx;
    logic [ADDR_BITS-1:0] r_rd_addr;
    rd_tag_t [RD_LAT:0]   r_vld_pipe;

    logic [ADDR_BITS-2:0] w_idx_use;
    logic [ADDR_BITS-2:0] w_grp_max;
    logic                 w_is_last;
    rd_tag_t              w_tag;

    // A restart in the same cycle as a request redirects that request to group 0.
    assign w_idx_use = i_restart ? '0 : r_idx;
    assign w_grp_max = i_groups - G_ONE;
    assign w_is_last = (w_idx_use == w_grp_max);
    assign w_tag.vld  = i_req;
    assign w_tag.last = i_req && w_is_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx      <= '0;
            r_rd_addr  <= '0;
            r_vld_pipe <= '0;
        end else if (i_flush) begin
            r_idx      <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_tag};
            if (i_req) begin
                r_rd_addr <= {1'b0, w_idx_use};
                r_idx     <= w_is_last ? '0 : w_idx_use + G_ONE;
            end else if (i_restart) begin
                r_idx <= '0;
            end
        end
    end

    assign o_rd_addr = r_rd_addr;
    assign o_valid   = r_vld_pipe[RD_LAT].vld;
    assign o_last    = r_vld_pipe[RD_LAT].last;
endmodule

// File: rtl/bias_ram_ctrl.sv
// Bias RAM controller: load FSM and write path from the stream; group reads via bias_rd_seq.
module bias_ram_ctrl
    import bias_ram_ctrl_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int RD_LAT    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_load,
    input  logic [ADDR_BITS-2:0]         load_groups,
    input  logic [AXI_WIDTH_DATA_IN-1:0] s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [AXI_WIDTH_DATA_IN-1:0] ram_wr_data,
    output logic [ADDR_BITS-1:0]         ram_wr_addr,
    output logic                         ram_wr_en,
    output logic                         load_done,
    output logic                         bias_loaded,
    input  logic                         grp_restart,
    input  logic                         grp_req,
    output logic [ADDR_BITS-1:0]         ram_rd_addr,
    output logic                         bias_valid,
    output logic                         grp_last,
    output logic                         req_err
);
    localparam logic [ADDR_BITS-1:0] W_ONE = 1;

    logic [1:0]                   r_state;
    logic [ADDR_BITS-2:0]         r_groups;
    logic [ADDR_BITS-1:0]         r_target;
    logic [ADDR_BITS-1:0]         r_wcnt;
    logic [AXI_WIDTH_DATA_IN-1:0] r_wr_data;
    logic [ADDR_BITS-1:0]         r_wr_addr;
    logic                         r_wr_en;
    logic                         r_done;
    logic                         r_loaded;
    logic                         r_err;

    logic w_in_load;
    logic w_beats_left;
    logic w_hs;
    logic w_start;
    logic w_rd_req;

    assign w_in_load    = (r_state == BIAS_LOAD);
    assign w_beats_left = (r_wcnt != r_target);
    assign s_ready      = w_in_load && w_beats_left;
    assign w_hs         = s_valid && s_ready;
    assign w_start      = start_load && !w_in_load;
    // start_load wins over a same-cycle request in READY.
    assign w_rd_req     = grp_req && (r_state == BIAS_READY) && !start_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= BIAS_IDLE;
            r_groups  <= '0;
            r_target  <= '0;
            r_wcnt    <= '0;
            r_wr_data <= '0;
            r_wr_addr <= '0;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_loaded  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= w_hs;
            r_done  <= 1'b0;
            if (w_hs) begin
                r_wr_addr <= r_wcnt;
                r_wr_data <= s_data;
                r_wcnt    <= r_wcnt + W_ONE;
            end
            if (w_start) begin
                r_groups <= load_groups;
                r_target <= {load_groups, 1'b0};
                r_wcnt   <= '0;
                r_loaded <= 1'b0;
                r_err    <= 1'b0;
                r_done   <= (load_groups == '0);
                r_state  <= (load_groups == '0) ? BIAS_IDLE : BIAS_LOAD;
            end else begin
                if (grp_req && r_state != BIAS_READY)
                    r_err <= 1'b1;
                // Final write was registered last cycle; finish one cycle later.
                if (w_in_load && !w_beats_left) begin
                    r_done   <= 1'b1;
                    r_loaded <= 1'b1;
                    r_state  <= BIAS_READY;
                end
            end
        end
    end

    assign ram_wr_data = r_wr_data;
    assign ram_wr_addr = r_wr_addr;
    assign ram_wr_en   = r_wr_en;
    assign load_done   = r_done;
    assign bias_loaded = r_loaded;
    assign req_err     = r_err;

    bias_rd_seq #(
        .ADDR_BITS (ADDR_BITS),
        .RD_LAT    (RD_LAT)
    ) u_rd_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_rd_req),
        .i_restart (grp_restart),
        .i_flush   (w_start),
        .i_groups  (r_groups),
        .o_rd_addr (ram_rd_addr),
        .o_valid   (bias_valid),
        .o_last    (grp_last)
    );
endmodule

// File: tb/tb_bias_ram_ctrl.sv
// Bench for bias_ram_ctrl: directed scenarios plus random traffic against a transaction-level model.
module tb_bias_ram_ctrl;
    import bias_ram_ctrl_pkg::*;

    localparam int AB = 8;
    localparam int RL = 2;
    localparam int DW = AXI_WIDTH_DATA_IN;

    logic          clk, rst_n;
    logic          start_load;
    logic [AB-2:0] load_groups;
    logic [DW-1:0] s_data;
    logic          s_valid, s_ready;
    logic [DW-1:0] ram_wr_data;
    logic [AB-1:0] ram_wr_addr, ram_rd_addr;
    logic          ram_wr_en, load_done, bias_loaded;
    logic          grp_restart, grp_req, bias_valid, grp_last, req_err;

    bias_ram_ctrl #(.ADDR_BITS(AB), .RD_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .start_load(start_load), .load_groups(load_groups),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
        .load_done(load_done), .bias_loaded(bias_loaded), .grp_restart(grp_restart),
        .grp_req(grp_req), .ram_rd_addr(ram_rd_addr), .bias_valid(bias_valid),
        .grp_last(grp_last), .req_err(req_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_wr, n_vld, n_last;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: loads are beat lists, reads are scheduled completions in a queue.
    typedef struct { int due; bit last; } pend_t;
    pend_t pq[$];
    int m_st;  // 0 no set, 1 loading, 2 loaded
    int m_groups, m_need, m_wcnt, m_idx;
    logic          e_sready, e_wr_en, e_done, e_loaded, e_err;
    logic [AB-1:0] e_wr_addr, e_rd_addr;
    logic [DW-1:0] e_wr_data;

    task automatic model_reset();
        m_st = 0; m_groups = 0; m_need = 0; m_wcnt = 0; m_idx = 0;
        e_sready = 0; e_wr_en = 0; e_done = 0; e_loaded = 0; e_err = 0;
        e_wr_addr = '0; e_rd_addr = '0; e_wr_data = '0;
        pq.delete();
    endtask

    task automatic model_step();
        pend_t p;
        int g;
        e_wr_en = 0;
        e_done  = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_st == 1) begin
            if (m_need == 0) begin
                e_done = 1; e_loaded = 1; m_st = 2;
            end else if (s_valid) begin
                e_wr_en = 1; e_wr_addr = m_wcnt[AB-1:0]; e_wr_data = s_data;
                m_wcnt++; m_need--;
            end
            if (grp_req) e_err = 1;
            if (grp_restart) m_idx = 0;
        end else if (start_load) begin
            m_groups = int'(load_groups);
            m_wcnt = 0; m_need = 2 * m_groups; m_idx = 0;
            e_loaded = 0; e_err = 0;
            pq.delete();
            if (m_groups == 0) begin e_done = 1; m_st = 0; end
            else m_st = 1;
        end else if (grp_req && m_st == 2) begin
            g = grp_restart ? 0 : m_idx;
            e_rd_addr = g[AB-1:0];
            p.due = cyc + 1 + RL;
            p.last = (g == m_groups - 1);
            pq.push_back(p);
            m_idx = (g + 1) % m_groups;
        end else begin
            if (grp_req) e_err = 1;
            if (grp_restart) m_idx = 0;
        end
        e_sready = (m_st == 1) && (m_need > 0);
    endtask

    task automatic check_all();
        pend_t p;
        bit ev, el;
        ev = 0; el = 0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            p = pq.pop_front();
            ev = 1; el = p.last;
        end
        chk("s_ready", s_ready, e_sready);
        chk("wr_en", ram_wr_en, e_wr_en);
        chk("wr_addr", ram_wr_addr, e_wr_addr);
        chk("wr_data", ram_wr_data, e_wr_data);
        chk("load_done", load_done, e_done);
        chk("bias_loaded", bias_loaded, e_loaded);
        chk("req_err", req_err, e_err);
        chk("rd_addr", ram_rd_addr, e_rd_addr);
        chk("bias_valid", bias_valid, ev);
        chk("grp_last", grp_last, el);
        n_wr   += int'(ram_wr_en);
        n_vld  += int'(bias_valid);
        n_last += int'(bias_valid && grp_last);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [DW-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_load(input int lg, input bit toggle, input bit seqd, input int stop_at,
                           input bit with_req);
        int  k, guard, tgt;
        logic [DW-1:0] d;
        bit  acc;
        tgt = (stop_at >= 0) ? stop_at : 2 * lg;
        start_load = 1; load_groups = lg[AB-2:0]; grp_req = with_req;
        step();
        start_load = 0; grp_req = 0;
        if (with_req) chk("start_wins_sready", s_ready, 1);
        n_wr = 0; k = 0; guard = 0;
        while (k < tgt && guard < 4 * tgt + 20) begin
            s_valid = toggle ? (guard % 2 == 0) : 1'b1;
            d = k + 1;
            s_data = seqd ? d : rnd_beat();
            acc = s_valid && e_sready;
            step();
            if (acc) k++;
            guard++;
        end
        s_valid = 0;
        chk("load_beats", k, tgt);
    endtask

    initial begin
        rst_n = 0; start_load = 0; load_groups = '0; s_data = '0; s_valid = 0;
        grp_restart = 0; grp_req = 0;
        n_wr = 0; n_vld = 0; n_last = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1;

        // 1: continuous load of 3 groups, data 1..6
        do_load(3, 0, 1, -1, 0);
        repeat (2) step();
        chk("t1_writes", n_wr, 6);
        chk("t1_loaded", bias_loaded, 1);

        // 2: same load with s_valid toggling
        do_load(3, 1, 1, -1, 0);
        repeat (2) step();
        chk("t2_writes", n_wr, 6);
        chk("t2_sready_after", s_ready, 0);

        // 3: five back-to-back requests over 3 groups
        n_vld = 0; n_last = 0;
        grp_req = 1;
        repeat (5) step();
        grp_req = 0;
        repeat (RL + 2) step();
        chk("t3_valids", n_vld, 5);
        chk("t3_lasts", n_last, 1);

        // 4: restart with request, then start_load colliding with a request
        grp_req = 1;
        repeat (2) step();
        grp_restart = 1; step(); grp_restart = 0;
        step();
        step();
        do_load(2, 0, 0, -1, 1);
        repeat (2) step();

        // 5: request with no set loaded, zero-group load
        do_load(0, 0, 0, -1, 0);
        chk("t5_zero_done", load_done, 1);
        step();
        grp_req = 1; step(); grp_req = 0;
        chk("t5_err_set", req_err, 1);
        repeat (RL + 1) step();
        do_load(0, 0, 0, -1, 0);
        chk("t5_err_clr", req_err, 0);
        chk("t5_idle_sready", s_ready, 0);
        step();

        // 6: reset after 3 of 6 beats
        do_load(3, 0, 0, 3, 0);
        rst_n = 0;
        #1;
        chk("t6_wr_en", ram_wr_en, 0);
        chk("t6_loaded", bias_loaded, 0);
        chk("t6_sready", s_ready, 0);
        chk("t6_wr_addr", ram_wr_addr, 0);
        model_reset();
        step();
        rst_n = 1;
        grp_req = 1; step(); grp_req = 0;
        chk("t6_err", req_err, 1);
        step();

        // Largest group count, reads across the wrap point
        do_load(127, 0, 0, -1, 0);
        repeat (2) step();
        n_vld = 0; n_last = 0;
        grp_req = 1;
        repeat (130) step();
        grp_req = 0;
        repeat (RL + 2) step();
        chk("max_valids", n_vld, 130);
        chk("max_lasts", n_last, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst_n       = ($urandom % 200 != 0);
            start_load  = ($urandom % 30 == 0);
            load_groups = AB'($urandom_range(0, 4));
            grp_req     = $urandom % 2;
            grp_restart = ($urandom % 8 == 0);
            s_valid     = ($urandom % 4 != 0);
            s_data      = rnd_beat();
            step();
        end
        rst_n = 1; start_load = 0; grp_req = 0; grp_restart = 0; s_valid = 0;
        repeat (RL + 2) step();
        chk("pending_drained", pq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
